// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // 20 bit-times at 115200 baud with a 50 MHz clock
    localparam int DEFAULT_TIMEOUT_CYCLES = 8680;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic             found
);

    int best_s;
    int win_s;
    int dist_s;

    // Smallest rotated distance from ptr+1 wins
    always_comb begin
        best_s = N_REQ;
        win_s  = 0;
        dist_s = 0;
        for (int i = 0; i < N_REQ; i++) begin
            dist_s = (i + N_REQ - 1 - int'(ptr)) % N_REQ;
            if (req[i] && (dist_s < best_s)) begin
                best_s = dist_s;
                win_s  = i;
            end else begin
                best_s = best_s;
            end
        end
        found = (best_s < N_REQ);
        for (int i = 0; i < N_REQ; i++) begin
            winner[i] = found && (i == win_s);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of uart_tx.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t       state_r;
    logic [N_REQ-1:0] grant_r;
    logic [PW-1:0]    ptr_r;
    logic [N_REQ-1:0] pick_s;
    logic             pick_valid_s;
    logic [PW-1:0]    g_s;
    logic [7:0]       bytes_s [N_REQ];
    logic             xfer_s;
    logic             done_s;
    logic             expire_s;

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign bytes_s[i] = req_data[8*i +: 8];
    end

    rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req    (req_valid),
        .ptr    (ptr_r),
        .winner (pick_s),
        .found  (pick_valid_s)
    );

    assign g_s    = PW'(onehot_to_idx(8'(grant_r)));
    assign xfer_s = (state_r == GRANT) && req_valid[g_s] && tx_ready;
    assign done_s = xfer_s && req_last[g_s];
    assign grant  = grant_r;
    assign busy   = (state_r == GRANT);

    // Arbitration FSM, grant register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= PW'(N_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_r <= GRANT;
                        grant_r <= pick_s;
                    end
                end
                GRANT: begin
                    if (done_s || expire_s) begin
                        state_r <= IDLE;
                        grant_r <= '0;
                        ptr_r   <= g_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Zero-latency handshake passthrough for the granted source
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state_r == GRANT) begin
            tx_data        = bytes_s[g_s];
            tx_valid       = req_valid[g_s];
            req_ready[g_s] = tx_ready;
        end else begin
            tx_valid = 1'b0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] stall_cnt_r;
    logic          timeout_r;
    logic          stall_s;

    // Sink backpressure is not the source's fault, so only count with tx_ready high
    assign stall_s  = (state_r == GRANT) && !req_valid[g_s] && tx_ready;
    assign expire_s = stall_s && (stall_cnt_r == CW'(TIMEOUT_CYCLES - 1));
    assign timeout  = timeout_r;

    // Stall counter and one-cycle revoke pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            timeout_r   <= 1'b0;
        end else begin
            timeout_r <= expire_s;
            if (state_r != GRANT || xfer_s) begin
                stall_cnt_r <= '0;
            end else if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + CW'(1);
            end
        end
    end
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized phase.
module tb_uart_tx_arbiter;

    localparam int N = 2;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    always #10 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Source byte stores: {last, byte}
    logic [8:0] mem [N][256];
    int  head [N];
    int  tail [N];
    int  stall_hold [N];
    bit  pending [N];
    bit  rand_gaps;
    bit  rand_rdy;

    // Reference model: owner of the transmitter (-1 idle), last served, stall count
    int  m_owner;
    int  m_ptr;
    int  m_cnt;
    bit  m_to;

    logic [7:0]   sink [$];
    int           glog [$];
    logic [N-1:0] prev_grant;
    int           g01_cnt;
    int           to_cnt;
    int           pushed;
    int           expect_to;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int src, input logic [7:0] b, input logic last);
        mem[src][tail[src] % 256] = {last, b};
        tail[src]++;
        pushed++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit v;
            v = (head[i] < tail[i]) && (stall_hold[i] == 0) &&
                (pending[i] || !rand_gaps || ($urandom_range(0, 2) != 0));
            if (stall_hold[i] > 0) stall_hold[i]--;
            req_valid[i]      = v;
            req_data[8*i +: 8] = v ? mem[i][head[i] % 256][7:0] : 8'($urandom);
            req_last[i]       = v ? mem[i][head[i] % 256][8] : 1'($urandom);
        end
        if (rand_rdy) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check();
        int o;
        o = m_owner;
        chk("grant", 32'(grant), (o >= 0) ? (1 << o) : 0);
        chk("busy", 32'(busy), (o >= 0) ? 1 : 0);
        chk("tx_valid", 32'(tx_valid), (o >= 0) ? 32'(req_valid[o]) : 0);
        if (o >= 0 && req_valid[o]) chk("tx_data", 32'(tx_data), 32'(req_data[8*o +: 8]));
        chk("req_ready", 32'(req_ready), (o >= 0 && tx_ready) ? (1 << o) : 0);
        chk("timeout", 32'(timeout), 32'(m_to));
        if (tx_valid === 1'b1 && tx_ready) sink.push_back(tx_data);
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
        end
        if (grant == 2'b01) g01_cnt++;
        if (timeout === 1'b1) to_cnt++;
        prev_grant = grant;
    endtask

    task automatic update();
        bit found;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_to = 1'b0;
            for (int i = 0; i < N; i++) begin
                head[i] = tail[i]; pending[i] = 1'b0; stall_hold[i] = 0;
            end
        end else if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1; m_owner = idx; m_cnt = 0;
                end
            end
            for (int i = 0; i < N; i++) pending[i] = req_valid[i];
        end else begin
            int o;
            o    = m_owner;
            m_to = 1'b0;
            for (int i = 0; i < N; i++) pending[i] = req_valid[i];
            if (req_valid[o] && tx_ready) begin
                head[o]++;
                pending[o] = 1'b0;
                m_cnt = 0;
                if (req_last[o]) begin
                    m_owner = -1; m_ptr = o;
                end
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!req_valid[o] && tx_ready) begin
                if (m_cnt == T - 1) begin
                    m_to = 1'b1; m_owner = -1; m_ptr = o;
                end else begin
                    m_cnt++;
                end
            end
`endif
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic int outstanding();
        int s;
        s = (m_owner >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) s += tail[i] - head[i];
        return s;
    endfunction

    task automatic drain(input int max_cycles, input string tag);
        int k;
        k = 0;
        while (outstanding() != 0 && k < max_cycles) begin
            cycle();
            k++;
        end
        chk(tag, 32'(outstanding()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
        rand_gaps = 1'b0; rand_rdy = 1'b0; prev_grant = '0;
        g01_cnt = 0; to_cnt = 0; pushed = 0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; stall_hold[i] = 0; pending[i] = 1'b0;
        end
        m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_to = 1'b0;
        @(posedge clk);
        #1;
        run(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Single 3-byte packet from source 0
        sink.delete(); g01_cnt = 0;
        push(0, 8'h7B, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h7D, 1'b1);
        run(6);
        chk("t1_len", 32'(sink.size()), 32'd3);
        if (sink.size() == 3) begin
            chk("t1_b0", 32'(sink[0]), 32'h7B);
            chk("t1_b1", 32'(sink[1]), 32'h22);
            chk("t1_b2", 32'(sink[2]), 32'h7D);
        end
        chk("t1_grant_cycles", 32'(g01_cnt), 32'd3);

        // Simultaneous 2-byte packets after reset: 0 then 1
        pulse_reset();
        glog.delete();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        run(8);
        chk("t2_pkts", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("t2_first", 32'(glog[0]), 32'd0);
            chk("t2_second", 32'(glog[1]), 32'd1);
        end

        // Continuous 1-byte packets alternate 0,1,0,1
        glog.delete();
        push(0, 8'hC0, 1'b1); push(0, 8'hC1, 1'b1);
        push(1, 8'hD0, 1'b1); push(1, 8'hD1, 1'b1);
        run(10);
        chk("t3_pkts", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 32'(glog[i]), 32'(i % 2));
        end

        // 100 cycles of sink backpressure mid-packet
        sink.delete();
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        run(2);
        tx_ready = 1'b0;
        run(100);
        tx_ready = 1'b1;
        run(5);
        chk("t4_len", 32'(sink.size()), 32'd3);
        if (sink.size() == 3) begin
            chk("t4_b0", 32'(sink[0]), 32'h11);
            chk("t4_b1", 32'(sink[1]), 32'h22);
            chk("t4_b2", 32'(sink[2]), 32'h33);
        end

        // Reset during byte 2 of 3
        push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b0); push(0, 8'h53, 1'b1);
        run(2);
        pulse_reset();
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx_valid", 32'(tx_valid), 32'd0);
        glog.delete();
        push(1, 8'h61, 1'b1); push(0, 8'h62, 1'b1);
        run(6);
        chk("t5_next_pick", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);

        // Source 0 stalls after its first byte
        pulse_reset();
        to_cnt = 0;
        push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b0); push(0, 8'h33, 1'b1);
        push(1, 8'h41, 1'b1);
        run(2);
        stall_hold[0] = 40;
        run(30);
`ifdef UART_ARB_TIMEOUT_EN
        expect_to = 1;
`else
        expect_to = 0;
        chk("t6_grant_held", 32'(grant), 32'd1);
`endif
        run(15);
        chk("t6_timeouts", 32'(to_cnt), 32'(expect_to));
        drain(200, "t6_drain");

        // Randomized traffic with source gaps and sink backpressure
        pulse_reset();
        sink.delete(); pushed = 0;
        rand_gaps = 1'b1; rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int src, len;
            src = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) push(src, 8'($urandom), (b == len - 1));
        end
        drain(3000, "t7_drain");
        rand_gaps = 1'b0; rand_rdy = 1'b0; tx_ready = 1'b1;
        chk("t7_bytes", 32'(sink.size()), 32'(pushed));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx byte transmitter between N_REQ message sources, e.g. the JSON command controller and a servo status reporter. Arbitration is round-robin at packet granularity: once a source is granted, it owns the transmitter until its last byte is accepted. The block sits between the sources and uart_tx, and passes the valid/ready handshake through for the granted source.

Parameters:
N_REQ, 2, number of requesting sources (2..8).
TIMEOUT_CYCLES, 8680, stall limit in clk cycles for the granted source; only used with the optional feature.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
req_data  in  8*N_REQ  byte from each source; source i occupies bits [8i+7:8i]
req_valid  in  N_REQ  per-source byte valid
req_last  in  N_REQ  marks the final byte of a packet; qualified by req_valid
req_ready  out  N_REQ  per-source byte accepted when req_valid[i] && req_ready[i]
tx_data  out  8  byte to uart_tx data_tx
tx_valid  out  1  to uart_tx valid
tx_ready  in  1  from uart_tx ready
grant  out  N_REQ  one-hot grant; all zero when idle
busy  out  1  high while a packet is in progress
timeout  out  1  one-cycle pulse when a stalled grant is revoked; tied 0 without the macro

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - grant=0, busy=0, timeout=0, state=IDLE.
  - rr pointer = N_REQ-1, so source 0 wins the first arbitration.
  - Consequences: tx_valid=0, req_ready=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from pointer+1, wrapping modulo N_REQ.
  - Register the one-hot grant and go to GRANT. Arbitration latency is 1 cycle.
  - No byte is transferred while in IDLE.
- GRANT, with g = granted index (combinational passthrough, 0 latency):
  - tx_data = req_data[g], tx_valid = req_valid[g], req_ready[g] = tx_ready.
  - req_ready is 0 for all other sources.
- Transfer: a byte transfers on a cycle where tx_valid && tx_ready.
  - If req_last[g] is also set: next state is IDLE, grant clears, pointer is set to g.
  - There is always one idle bubble cycle between packets.
- Backpressure: while tx_ready is low, no state change occurs. The source must hold its data stable (standard valid/ready rule).
- busy = (state==GRANT).
- Requests from non-granted sources are ignored until the next IDLE cycle. Those sources see ready=0 and lose no data.
- rst asserted mid-packet: the next cycle is IDLE with grant=0 and tx_valid=0. A byte already shifted by uart_tx completes on its own. The partial packet is not resumed.
- Single-source case: a lone requester is re-granted after the 1-cycle bubble.
- Pointer fairness: a source that has just finished has the lowest priority in the next arbitration.

Optional Feature:
UART_ARB_TIMEOUT_EN
- With the macro defined:
  - A counter runs in GRANT on cycles where req_valid[g]==0.
  - The counter clears on each accepted byte and on entry to GRANT. Cycles with tx_ready low (sink backpressure) do not increment it.
  - When the count reaches TIMEOUT_CYCLES-1 with the source still stalled: pulse timeout for one cycle, go to IDLE, clear grant, set pointer to g.
- Without the macro: no counter is built, timeout is constant 0, and a grant is held indefinitely until req_last is accepted.

Decomposition:
- Package uart_arb_pkg contains:
  - state enum typedef arb_state_t {IDLE, GRANT};
  - localparam DEFAULT_TIMEOUT_CYCLES = 8680 (20 bit-times at 115200 baud);
  - a function that returns the index of a one-hot vector.
- Sub-module rr_picker (purely combinational): inputs are the request vector and the pointer; output is the one-hot winner plus a valid flag.
- FSM, grant register and datapath mux stay in uart_tx_arbiter.

Test Plan:
- Source 0 sends 0x7B,0x22,0x7D (last on 0x7D) with tx_ready always 1 → tx sees 7B,22,7D in order; grant=01 for 3 cycles; busy falls the cycle after 0x7D.
- After reset, both sources are valid in the same cycle with 2-byte packets → source 0 is served first, then source 1 after a 1-cycle bubble; req_ready[1] stays 0 during source 0's packet.
- Both sources continuously request 1-byte packets → grant order 0,1,0,1 across 4 packets.
- tx_ready is held 0 for 100 cycles mid-packet → tx_data and tx_valid are stable; req_ready[g]=0; no byte is dropped or duplicated after ready returns.
- rst is pulsed for 1 cycle during byte 2 of 3 → next cycle grant=0, tx_valid=0, busy=0; the following arbitration picks source 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, source 0 drops valid after byte 1 → timeout is high for exactly 1 cycle, 16 cycles after the stall starts; source 1 is then granted. Without the macro, grant=01 persists.
